// File: rtl/i2c_byte_master.sv
// I2C master byte engine: runs one START/STOP/WRITE/READ command at a time as
// open-drain SCL/SDA quarter-phase sequences and returns a one-cycle response.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; wr_data is captured on that edge and the inputs may
// change afterwards. rsp_valid is high for exactly one cycle per accepted
// command; rsp_* stay stable until the next response. cmd_ready stays low from
// the cycle after acceptance through the rsp_valid cycle.
module i2c_byte_master #(
  parameter int CLK_DIV        = 4,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd,
  input  logic [I2C_DATA_WIDTH-1:0] wr_data,
  output logic                      rsp_valid,
  output logic [I2C_DATA_WIDTH-1:0] rsp_data,
  output logic                      rsp_nack,
  output logic                      rsp_err,
  output logic                      scl_oe,
  output logic                      sda_oe,
  input  logic                      sda_i,
  output logic [2:0]                dbg_state
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [QW-1:0] Q_MAX   = QW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_ACK = BW'(I2C_DATA_WIDTH);

  localparam logic [2:0] CMD_START = 3'd0;
  localparam logic [2:0] CMD_STOP  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_RDACK = 3'd3;
  localparam logic [2:0] CMD_RDNAK = 3'd4;

  typedef enum logic [2:0] {
    S_READY     = 3'd0,
    S_RUN_START = 3'd1,
    S_RUN_STOP  = 3'd2,
    S_RUN_BYTE  = 3'd3,
    S_RESP      = 3'd4
  } ops_t;

  ops_t                      state, state_d;
  logic                      bus_taken;
  logic                      err_pend;
  logic                      err_q;
  logic [2:0]                op_q;
  logic [QW-1:0]             qcnt;
  logic [1:0]                qidx;
  logic [BW-1:0]             bit_idx;
  logic [I2C_DATA_WIDTH-1:0] tx_sh;
  logic [I2C_DATA_WIDTH-1:0] rx_sh;
  logic                      ack_q;
  logic                      scl_d, sda_d;
  logic                      accept, cmd_legal, running, q_last, bit_end, sample_pt;
  logic                      is_read, data_bit, drive_low;

  assign dbg_state = state;
  // Error responses spend one decode cycle (err_pend) before RESP; the extra
  // rsp_valid term keeps cmd_ready low during the response pulse itself.
  assign cmd_ready = (state == S_READY) && !rsp_valid && !err_pend;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_legal = (cmd == CMD_START) ||
                     (bus_taken && (cmd == CMD_STOP || cmd == CMD_WRITE ||
                                    cmd == CMD_RDACK || cmd == CMD_RDNAK));
  assign running   = (state == S_RUN_START) || (state == S_RUN_STOP) ||
                     (state == S_RUN_BYTE);
  assign q_last    = (qcnt == '0);
  assign bit_end   = q_last && (qidx == 2'd3);
  // Bus pins are registered, so the last Q2 clock on the wire coincides with
  // the first internal Q3 clock.
  assign sample_pt = (qidx == 2'd3) && (qcnt == Q_MAX);
  assign is_read   = (op_q == CMD_RDACK) || (op_q == CMD_RDNAK);
  assign data_bit  = (bit_idx < BIT_ACK);
  // Data bits: write drives the MSB, reads release. Ack slot: only READ_ACK pulls low.
  assign drive_low = data_bit ? ((op_q == CMD_WRITE) && !tx_sh[I2C_DATA_WIDTH-1])
                              : (op_q == CMD_RDACK);

  // Next ops state and next open-drain pin values for the current quarter.
  always_comb begin
    state_d = state;
    scl_d   = scl_oe;
    sda_d   = sda_oe;
    case (state)
      S_READY: begin
        if (err_pend) begin
          state_d = S_RESP;
        end else if (accept && cmd_legal) begin
          case (cmd)
            CMD_START: state_d = S_RUN_START;
            CMD_STOP:  state_d = S_RUN_STOP;
            default:   state_d = S_RUN_BYTE;
          endcase
        end
      end
      S_RUN_START: begin
        case (qidx)
          2'd0:    sda_d = 1'b0;
          2'd1:    scl_d = 1'b0;
          2'd2:    sda_d = 1'b1;
          default: scl_d = 1'b1;
        endcase
        if (bit_end) state_d = S_RESP;
      end
      S_RUN_STOP: begin
        case (qidx)
          2'd0: begin
            sda_d = 1'b1;
            scl_d = 1'b1;
          end
          2'd1:    scl_d = 1'b0;
          2'd2:    sda_d = 1'b0;
          default: ;
        endcase
        if (bit_end) state_d = S_RESP;
      end
      S_RUN_BYTE: begin
        case (qidx)
          2'd0: begin
            scl_d = 1'b1;
            sda_d = drive_low;
          end
          2'd1, 2'd2: scl_d = 1'b0;
          default:    scl_d = 1'b1;
        endcase
        if (bit_end && (bit_idx == BIT_ACK)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_READY;
      default: state_d = S_READY;
    endcase
  end

  // State, pins, timing counters, shift registers and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_READY;
      bus_taken <= 1'b0;
      err_pend  <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= '0;
      qcnt      <= '0;
      qidx      <= '0;
      bit_idx   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      ack_q     <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_nack  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state  <= state_d;
      scl_oe <= scl_d;
      sda_oe <= sda_d;
      if (accept) begin
        op_q     <= cmd;
        tx_sh    <= wr_data;
        rx_sh    <= '0;
        ack_q    <= 1'b0;
        qcnt     <= Q_MAX;
        qidx     <= 2'd0;
        bit_idx  <= '0;
        err_pend <= !cmd_legal;
        err_q    <= !cmd_legal;
      end else if (err_pend) begin
        err_pend <= 1'b0;
      end
      if (running) begin
        if (q_last) begin
          qcnt <= Q_MAX;
          qidx <= qidx + 2'd1;
          if ((qidx == 2'd3) && (state == S_RUN_BYTE)) begin
            bit_idx <= bit_idx + 1'b1;
            tx_sh   <= {tx_sh[I2C_DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          qcnt <= qcnt - 1'b1;
        end
      end
      if ((state == S_RUN_BYTE) && sample_pt) begin
        if (data_bit) rx_sh <= {rx_sh[I2C_DATA_WIDTH-2:0], sda_i};
        else          ack_q <= sda_i;
      end
      if ((state == S_RUN_START) && bit_end) bus_taken <= 1'b1;
      if ((state == S_RUN_STOP) && bit_end)  bus_taken <= 1'b0;
      rsp_valid <= (state == S_RESP);
      if (state == S_RESP) begin
        rsp_data <= (is_read && !err_q) ? rx_sh : '0;
        rsp_nack <= (op_q == CMD_WRITE) && !err_q && ack_q;
        rsp_err  <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master: a tiny open-drain slave driven from the
// SCL fall count, a bus monitor for START/STOP conditions, and hand-computed
// expectations checked with immediate assertions.
module tb_i2c_byte_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] wr_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_err;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(4), .I2C_DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .rsp_err   (rsp_err),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i),
    .dbg_state (dbg_state)
  );

  // Open-drain bus with a simple slave: mode 1 acks a written byte, mode 2
  // shifts out rd_byte MSB first; bit k is driven after k SCL falls.
  logic       scl_line, sda_line, slave_low;
  int         slave_mode = 0;
  logic [7:0] rd_byte = 8'h00;
  int         falls = 0;
  int         base = 0;
  int         rel;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic [8:0] cap = '0;

  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | slave_low);
  assign sda_i    = sda_line;
  assign rel      = falls - base;

  always_comb begin
    slave_low = 1'b0;
    if (slave_mode == 1) slave_low = (rel == 8);
    else if (slave_mode == 2 && rel >= 0 && rel < 8) slave_low = !rd_byte[7-rel];
  end

  always @(negedge scl_line) falls <= falls + 1;
  always @(posedge scl_line) cap <= {cap[7:0], sda_line};
  always @(negedge sda_line) if (scl_line === 1'b1) start_cnt <= start_cnt + 1;
  always @(posedge sda_line) if (scl_line === 1'b1) stop_cnt <= stop_cnt + 1;

  // scoreboard results of the last command
  int         lat;
  logic       got;
  logic [7:0] r_data;
  logic       r_nack, r_err, any_oe, all_scl, post_valid, post_ready;
  logic [7:0] post_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: issue one command and collect its response
  task automatic do_cmd(input logic [2:0] c, input logic [7:0] d, input int mode,
                        input logic [7:0] rb);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_before_issue", 32'(cmd_ready), 1);
    slave_mode = mode;
    rd_byte    = rb;
    base       = falls;
    cmd        = c;
    wr_data    = d;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = 3'($urandom_range(0, 7));
    wr_data   = 8'($urandom_range(0, 255));
    lat = 0; got = 1'b0; any_oe = 1'b0; all_scl = 1'b1;
    while (!got && lat < 3000) begin
      @(posedge clk);
      #1;
      lat++;
      any_oe  = any_oe | scl_oe | sda_oe;
      all_scl = all_scl & scl_oe;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_valid_seen", 32'(got), 1);
    r_data = rsp_data; r_nack = rsp_nack; r_err = rsp_err;
    @(posedge clk);
    #1;
    post_valid = rsp_valid; post_ready = cmd_ready; post_data = rsp_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, p0, w;
    logic seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_scl_oe", 32'(scl_oe), 0);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_nack_err", 32'({rsp_nack, rsp_err}), 0);
    rst_n = 1'b1;

    // WRITE while bus idle -> error at accept+2, no bus activity
    do_cmd(3'd2, 8'h5A, 0, 8'h00);
    chk("idle_write_lat", 32'(lat), 2);
    chk("idle_write_err", 32'(r_err), 1);
    chk("idle_write_nack", 32'(r_nack), 0);
    chk("idle_write_bus", 32'(any_oe), 0);
    chk("idle_write_pulse", 32'(post_valid), 0);
    chk("idle_write_ready_after", 32'(post_ready), 1);

    // START, WRITE 0x44, WRITE 0xA5, STOP
    s0 = start_cnt;
    do_cmd(3'd0, 8'h00, 0, 8'h00);
    chk("start_lat", 32'(lat), 17);
    chk("start_err", 32'(r_err), 0);
    chk("start_cond", 32'(start_cnt), 32'(s0 + 1));
    chk("start_pins", 32'({scl_oe, sda_oe}), 3);
    chk("start_ready_after", 32'(post_ready), 1);
    do_cmd(3'd2, 8'h44, 1, 8'h00);
    chk("wr44_lat", 32'(lat), 145);
    chk("wr44_nack", 32'(r_nack), 0);
    chk("wr44_bus_byte", 32'(cap[8:1]), 32'h44);
    do_cmd(3'd2, 8'hA5, 1, 8'h00);
    chk("wrA5_nack", 32'(r_nack), 0);
    chk("wrA5_bus_byte", 32'(cap[8:1]), 32'hA5);
    chk("wrA5_data_zero", 32'(r_data), 0);
    p0 = stop_cnt;
    do_cmd(3'd1, 8'h00, 0, 8'h00);
    chk("stop_lat", 32'(lat), 17);
    chk("stop_nack_err", 32'({r_nack, r_err}), 0);
    chk("stop_cond", 32'(stop_cnt), 32'(p0 + 1));
    chk("stop_pins_idle", 32'({scl_oe, sda_oe}), 0);

    // READ sequence: START, WRITE 0x45, READ_ACK 0x3C, READ_NAK 0xC3, STOP
    do_cmd(3'd0, 8'h00, 0, 8'h00);
    do_cmd(3'd2, 8'h45, 1, 8'h00);
    chk("wr45_nack", 32'(r_nack), 0);
    do_cmd(3'd3, 8'h00, 2, 8'h3C);
    chk("rdack_lat", 32'(lat), 145);
    chk("rdack_data", 32'(r_data), 32'h3C);
    chk("rdack_master_ack", 32'(cap[0]), 0);
    chk("rdack_nack", 32'(r_nack), 0);
    do_cmd(3'd4, 8'h00, 2, 8'hC3);
    chk("rdnak_data", 32'(r_data), 32'hC3);
    chk("rdnak_master_nak", 32'(cap[0]), 1);
    chk("rdnak_data_hold", 32'(post_data), 32'hC3);
    do_cmd(3'd1, 8'h00, 0, 8'h00);
    chk("rd_stop_err", 32'(r_err), 0);
    chk("rd_stop_data_zero", 32'(r_data), 0);

    // No slave: NACK, then a normal STOP
    do_cmd(3'd0, 8'h00, 0, 8'h00);
    do_cmd(3'd2, 8'h50, 0, 8'h00);
    chk("noslave_nack", 32'(r_nack), 1);
    p0 = stop_cnt;
    do_cmd(3'd1, 8'h00, 0, 8'h00);
    chk("noslave_stop_nack_err", 32'({r_nack, r_err}), 0);
    chk("noslave_stop_cond", 32'(stop_cnt), 32'(p0 + 1));
    chk("noslave_idle_pins", 32'({scl_oe, sda_oe}), 0);

    // Repeated start: START, WRITE 0x44, START, WRITE 0x45
    do_cmd(3'd0, 8'h00, 0, 8'h00);
    do_cmd(3'd2, 8'h44, 1, 8'h00);
    s0 = start_cnt; p0 = stop_cnt;
    do_cmd(3'd0, 8'h00, 0, 8'h00);
    chk("rstart_lat", 32'(lat), 17);
    chk("rstart_cond", 32'(start_cnt), 32'(s0 + 1));
    chk("rstart_no_stop", 32'(stop_cnt), 32'(p0));
    do_cmd(3'd2, 8'h45, 1, 8'h00);
    chk("rstart_addr_read", 32'(cap[8:1]), 32'h45);
    chk("rstart_wr_nack", 32'(r_nack), 0);

    // Reserved opcode while TAKEN
    do_cmd(3'd6, 8'h00, 0, 8'h00);
    chk("rsvd_lat", 32'(lat), 2);
    chk("rsvd_err", 32'(r_err), 1);
    chk("rsvd_scl_low", 32'(all_scl), 1);
    chk("rsvd_data_zero", 32'(r_data), 0);

    // Reset during bit 3 of a WRITE 0x00
    @(negedge clk);
    slave_mode = 0; base = falls; cmd = 3'd2; wr_data = 8'h00; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    w = 0;
    while (rel < 3 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("midop_reach", 32'(rel), 3);
    repeat (6) @(negedge clk);
    chk("midop_pins_before", 32'({scl_oe, sda_oe}), 3);
    rst_n = 1'b0;
    #1;
    chk("midop_async_pins", 32'({scl_oe, sda_oe}), 0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      seen = seen | rsp_valid;
    end
    chk("midop_no_rsp", 32'(seen), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midop_ready_after", 32'(cmd_ready), 1);
    do_cmd(3'd0, 8'h00, 0, 8'h00);
    chk("midop_start_lat", 32'(lat), 17);
    chk("midop_start_err", 32'(r_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Synthesizable I2C master byte engine: upstream stage that generates the SCL/SDA traffic consumed by the I2C slave BFM and slave devices.
- Accepts one command at a time (START, STOP, WRITE, READ_ACK, READ_NAK) from the Wishbone-side command logic.
- Executes the command as open-drain bit sequences and returns a one-cycle response with read data and ack status.

Parameters:
- CLK_DIV, 4, system clocks per SCL quarter-period; legal range is 1 or more; one SCL bit = 4*CLK_DIV clocks.
- I2C_DATA_WIDTH, 8, bits per data byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command.
- cmd  in  3  0=START, 1=STOP, 2=WRITE, 3=READ_ACK, 4=READ_NAK; 5-7 reserved.
- wr_data  in  I2C_DATA_WIDTH  byte for WRITE, sampled on accept.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  I2C_DATA_WIDTH  byte received by READ_*; otherwise 0.
- rsp_nack  out  1  WRITE: sampled 9th-bit SDA (1=NACK); otherwise 0.
- rsp_err  out  1  illegal command or sequencing error.
- scl_oe  out  1  1 pulls SCL low, 0 releases it.
- sda_oe  out  1  1 pulls SDA low, 0 releases it.
- sda_i  in  1  resolved SDA line.

Behaviour:
- Reset (async, immediate): scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_nack=0, rsp_err=0. Bus state returns to IDLE. A reset during a command abandons it; no response is issued.
- Bus states: IDLE (SCL and SDA released) and TAKEN (master holds SCL low).
- Ops states: READY, RUN_START, RUN_STOP, RUN_BYTE, RESP.
- Timing counters:
  - Quarter counter runs CLK_DIV-1 down to 0.
  - Quarter index runs Q0..Q3.
  - Bit index runs 0..I2C_DATA_WIDTH (the final bit is the ack slot).
- Handshake:
  - cmd_ready=1 only in READY.
  - A command is accepted on clk when cmd_valid&cmd_ready; cmd_ready drops the next cycle.
  - After the last Q3 clock, RESP asserts rsp_valid for exactly one cycle, with rsp_* stable during that cycle.
  - cmd_ready rises in the cycle after rsp_valid.
  - rsp_* hold their values until the next response.
- START (legal in IDLE or TAKEN; from TAKEN it is a repeated start):
  - Q0: SDA released; SCL unchanged.
  - Q1: SCL released.
  - Q2: SDA low with SCL high.
  - Q3: SCL low.
  - Final state: TAKEN.
- STOP (TAKEN only):
  - Q0: SDA low, SCL low.
  - Q1: SCL released.
  - Q2: SDA released.
  - Q3: hold.
  - Final state: IDLE.
- Data bit (used by WRITE and READ):
  - Q0: SCL low; SDA set to the bit value (sda_oe=~bit), or released for read bits and the write ack slot.
  - Q1 and Q2: SCL released.
  - Q3: SCL low.
  - sda_i is sampled on the last clock of Q2.
  - SDA changes only while SCL is low.
- WRITE (TAKEN only):
  - Sends I2C_DATA_WIDTH bits MSB first, then a released ack bit.
  - rsp_nack = sampled ack value.
- READ_ACK / READ_NAK (TAKEN only):
  - Sends I2C_DATA_WIDTH released bits and shifts the samples in MSB first into rsp_data.
  - The 9th bit drives SDA low (ACK) or releases it (NAK).
- Latency from accept to rsp_valid:
  - START/STOP: 4*CLK_DIV+1 clocks.
  - WRITE/READ: 4*CLK_DIV*(I2C_DATA_WIDTH+1)+1 clocks.
- Errors: STOP/WRITE/READ in IDLE, or a reserved opcode, give a response with rsp_err=1 two clocks after accept. No bus activity occurs and the bus state is unchanged.
- cmd_valid while busy is ignored (no queuing). The command does not need to stay stable after acceptance.
- No clock stretching and no arbitration; SCL is never sampled.

Test Plan:
- CLK_DIV=4, slave BFM at addr 0x22:
  - Commands: START, WRITE 0x44, WRITE 0xA5, STOP.
  - BFM reports a write of [0xA5].
  - Each rsp_nack=0; START/STOP rsp_valid 17 clocks after accept, WRITE 145 clocks.
- READ sequence:
  - Commands: START, WRITE 0x45, READ_ACK, READ_NAK, STOP, with the BFM providing [0x3C,0xC3].
  - rsp_data=0x3C then 0xC3.
  - The BFM sees ACK after byte 0 and NACK after byte 1, giving transfer_complete=1.
- WRITE with no slave responding (SDA floats high) gives rsp_nack=1; the following STOP completes normally and the bus returns to IDLE.
- Repeated start: START, WRITE 0x44, START, WRITE 0x45.
  - SDA falls while SCL is high, with no STOP seen by the monitor.
  - The monitor reports a new transfer with addr 0x22, op READ.
- Error cases:
  - WRITE issued in IDLE gives rsp_err=1 at accept+2, with scl_oe and sda_oe held at 0.
  - cmd=6 in TAKEN gives rsp_err=1 and SCL stays low.
- Reset mid-op: deassert rst_n during bit 3 of a WRITE.
  - scl_oe and sda_oe go to 0 asynchronously, with no rsp_valid.
  - After release, cmd_ready=1 and START is accepted.
